// File: rtl/veririsc_controller_pkg.sv
// veririsc_controller_pkg: shared VeriRISC opcode/phase encodings and the
// control-strobe bundle passed from the decoder to the controller top.
//   opcode_t : 3-bit instruction opcode held in the IR
//   phase_t  : 3-bit instruction-sequencer phase
//   ctrl_t   : the nine datapath control signals
package veririsc_controller_pkg;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic halt;
      logic inc_pc;
      logic ld_ac;
      logic ld_pc;
      logic wr;
      logic data_e;
   } ctrl_t;

   // Opcodes whose operand is read from memory and written into the accumulator.
   function automatic logic is_aluop(input opcode_t op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/veririsc_controller_decode.sv
// ctrl_decode: purely combinational phase/opcode/zero -> control decode.
// No enable gating and no halt override here; the controller top applies both.
//   phase  in  current sequencer phase
//   opcode in  current IR opcode
//   zero   in  accumulator-zero flag
//   ctrl   out ungated control signals
module ctrl_decode
   import veririsc_controller_pkg::*;
(
   input  phase_t  phase,
   input  opcode_t opcode,
   input  logic    zero,
   output ctrl_t   ctrl
);

   logic aluop;
   assign aluop = is_aluop(opcode);

   always_comb begin
      ctrl = '0;
      unique case (phase)
         INST_ADDR: begin
            ctrl.sel = 1'b1;
         end
         INST_FETCH: begin
            ctrl.sel = 1'b1;
            ctrl.rd  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            ctrl.sel   = 1'b1;
            ctrl.rd    = 1'b1;
            ctrl.ld_ir = 1'b1;
         end
         OP_ADDR: begin
            ctrl.halt   = (opcode == HLT);
            ctrl.inc_pc = 1'b1;
         end
         OP_FETCH: begin
            ctrl.rd = aluop;
         end
         ALU_OP: begin
            ctrl.rd     = aluop;
            // SKZ skips the next instruction by a second PC increment.
            ctrl.inc_pc = (opcode == SKZ) && zero;
            ctrl.ld_pc  = (opcode == JMP);
            ctrl.data_e = (opcode == STO);
         end
         STORE: begin
            ctrl.rd     = aluop;
            ctrl.ld_ac  = aluop;
            ctrl.ld_pc  = (opcode == JMP);
            ctrl.wr     = (opcode == STO);
            ctrl.data_e = (opcode == STO);
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/veririsc_controller.sv
// veririsc_controller: eight-phase VeriRISC instruction sequencer.
// Holds the phase and halted registers, gates strobes with ena and applies
// the halted override on top of the ctrl_decode outputs.
// Optional feature macro: CTRL_RESUME_EN (adds the resume input).
//   clk, rst_n   clock, async active-low reset
//   ena          phase-advance enable (low = stall)
//   opcode, zero IR opcode and ALU zero flag
//   resume       leave halted state (CTRL_RESUME_EN only)
//   sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e  control outputs
//   halted       sticky halted status
//   phase        current phase, for debug
module veririsc_controller
   import veririsc_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  opcode_t    opcode,
   input  logic       zero,
`ifdef CTRL_RESUME_EN
   input  logic       resume,
`endif
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       halt,
   output logic       inc_pc,
   output logic       ld_ac,
   output logic       ld_pc,
   output logic       wr,
   output logic       data_e,
   output logic       halted,
   output logic [2:0] phase
);

   phase_t phase_q, phase_d;
   logic   halted_q, halted_d;
   ctrl_t  dec;

   ctrl_decode u_decode (
      .phase  (phase_q),
      .opcode (opcode),
      .zero   (zero),
      .ctrl   (dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (halted_q) begin
`ifdef CTRL_RESUME_EN
         // Resume ignores ena; the PC already moved past HLT in OP_ADDR.
         if (resume) begin
            halted_d = 1'b0;
            phase_d  = OP_FETCH;
         end
`endif
      end else if (ena) begin
         // Enabled HLT in OP_ADDR parks the sequencer at OP_ADDR.
         if (phase_q == OP_ADDR && opcode == HLT) halted_d = 1'b1;
         else                                     phase_d  = phase_t'(phase_q + 3'd1);
      end
   end

   always_comb begin
      sel    = dec.sel;
      rd     = dec.rd;
      halt   = dec.halt;
      data_e = dec.data_e;
      ld_ir  = dec.ld_ir  & ena;
      inc_pc = dec.inc_pc & ena;
      ld_ac  = dec.ld_ac  & ena;
      ld_pc  = dec.ld_pc  & ena;
      wr     = dec.wr     & ena;
      if (halted_q) begin
         sel    = 1'b0;
         rd     = 1'b0;
         halt   = 1'b1;
         data_e = 1'b0;
         ld_ir  = 1'b0;
         inc_pc = 1'b0;
         ld_ac  = 1'b0;
         ld_pc  = 1'b0;
         wr     = 1'b0;
      end
   end

   assign halted = halted_q;
   assign phase  = phase_q;

endmodule

// File: tb/tb_veririsc_controller.sv
// tb_veririsc_controller: directed sequence with an expected-value queue.
// Each cycle the bench drives inputs, pushes the expected output vector from
// its own phase/halted model, then pops and compares at the falling edge.
module tb_veririsc_controller;
   import veririsc_controller_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   opcode_t    opcode;
   logic       zero;
   logic       resume;
   logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, halted;
   logic [2:0] phase;

   int tests = 0;
   int fails = 0;

   logic [12:0] expq[$];
   string       tagq[$];

   int   mph;
   logic mh;

   always #5 clk = ~clk;

   veririsc_controller dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .opcode (opcode),
      .zero   (zero),
`ifdef CTRL_RESUME_EN
      .resume (resume),
`endif
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .halt   (halt),
      .inc_pc (inc_pc),
      .ld_ac  (ld_ac),
      .ld_pc  (ld_pc),
      .wr     (wr),
      .data_e (data_e),
      .halted (halted),
      .phase  (phase)
   );

   // Vector order: sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e halted phase[2:0]
   function automatic logic [12:0] model_out(int ph, logic h, opcode_t op, logic z, logic e);
      logic alu;
      logic [2:0] p;
      p   = ph[2:0];
      alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
      if (h) return {3'b000, 1'b1, 5'b00000, 1'b1, p};
      return { (ph <= 3),
               ((ph >= 1 && ph <= 3) || (ph >= 5 && alu)),
               (e && (ph == 2 || ph == 3)),
               (ph == 4 && op == HLT),
               (e && (ph == 4 || (ph == 6 && op == SKZ && z))),
               (e && ph == 7 && alu),
               (e && (ph == 6 || ph == 7) && op == JMP),
               (e && ph == 7 && op == STO),
               ((ph == 6 || ph == 7) && op == STO),
               1'b0, p };
   endfunction

   function automatic logic [12:0] observed();
      return {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, halted, phase};
   endfunction

   // Run n cycles with fixed inputs; called just after a rising edge.
   task automatic cyc(input logic e, input opcode_t op, input logic z, input int n, input string tag);
      logic [12:0] exp_v;
      string t;
      for (int i = 0; i < n; i++) begin
         ena = e; opcode = op; zero = z;
         expq.push_back(model_out(mph, mh, op, z, e));
         tagq.push_back($sformatf("%s[%0d]", tag, i));
         @(negedge clk);
         exp_v = expq.pop_front();
         t     = tagq.pop_front();
         tests++;
         assert (observed() === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", t, observed(), exp_v);
         end
         @(posedge clk);
         if (mh) begin
            if (resume) begin mh = 1'b0; mph = 5; end
         end else if (e) begin
            if (mph == 4 && op == HLT) mh = 1'b1;
            else mph = (mph + 1) % 8;
         end
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b0; opcode = HLT; zero = 1'b0; resume = 1'b0;
      mph = 0; mh = 1'b0;
      @(negedge clk);
      check("reset_state", observed(), 13'b1_000000000_000);
      rst_n = 1'b1;
      @(posedge clk); #1;

      cyc(1'b1, LDA, 1'b0, 8, "lda");
      cyc(1'b1, SKZ, 1'b1, 8, "skz_z1");
      cyc(1'b1, SKZ, 1'b0, 8, "skz_z0");
      cyc(1'b1, STO, 1'b0, 8, "sto");
      cyc(1'b1, JMP, 1'b0, 8, "jmp");
      cyc(1'b1, XOR, 1'b1, 8, "xor");

      // Stall entering INST_LOAD
      cyc(1'b1, ADD, 1'b0, 2, "stall_pre");
      cyc(1'b0, ADD, 1'b0, 3, "stall");
      cyc(1'b1, ADD, 1'b0, 6, "stall_post");

      // Async reset in STORE of a STO
      cyc(1'b1, STO, 1'b0, 7, "sto_pre_rst");
      check("pre_rst_phase", {10'd0, phase}, 13'd7);
      rst_n = 1'b0;
      #1;
      check("async_rst", {sel, wr, data_e, halted, phase}, 13'b1_0_0_0_000);
      mph = 0; mh = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      mph = (ena) ? 1 : 0;

      // HLT, first stalled in OP_ADDR, then enabled
      cyc(1'b1, HLT, 1'b0, 4 - mph, "hlt_pre");
      cyc(1'b0, HLT, 1'b0, 2, "hlt_stall");
      cyc(1'b1, HLT, 1'b0, 1, "hlt_take");
      check("halted_rise", {halted, 9'd0, phase}, 13'b1_000000000_100);
      cyc(1'b1, HLT, 1'b0, 20, "halted_hold");

`ifdef CTRL_RESUME_EN
      resume = 1'b1;
      cyc(1'b0, HLT, 1'b0, 1, "resume_pulse");
      resume = 1'b0;
      check("resumed", {halted, 9'd0, phase}, 13'b0_000000000_101);
      cyc(1'b1, LDA, 1'b0, 3, "after_resume");
      cyc(1'b1, HLT, 1'b0, 5, "hlt_again");
`endif

      // Async reset while halted
      rst_n = 1'b0;
      #1;
      check("rst_halted", observed(), 13'b1_000000000_000);
      mph = 0; mh = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      mph = (ena) ? 1 : 0;
      cyc(1'b1, ADD, 1'b0, 8, "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/veririsc_controller.md
# veririsc_controller

Eight-phase instruction sequencer for the VeriRISC CPU. It decodes the current `opcode_t` from the instruction register and the ALU `zero` flag, and emits the per-phase control strobes that drive the PC, memory, IR, accumulator and data bus. It sits between the IR/ALU and the datapath, and owns the halt/stall state of the core.

## Interface
Parameters:
- None. Opcode width and encoding are fixed by `opcode_t` (3 bits).

Ports:
- `clk`  in  1  core clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  phase-advance enable; low stalls the controller, e.g. for a memory wait.
- `opcode`  in  3 (`opcode_t`)  current IR opcode.
- `zero`  in  1  accumulator-zero flag from the ALU.
- `resume`  in  1  leave the halted state. Present only with `CTRL_RESUME_EN`.
- `sel`  out  1  address mux select: 1 selects PC, 0 selects IR operand.
- `rd`  out  1  memory read.
- `ld_ir`  out  1  IR load strobe.
- `halt`  out  1  halt indication.
- `inc_pc`  out  1  PC increment strobe.
- `ld_ac`  out  1  accumulator load strobe.
- `ld_pc`  out  1  PC load strobe, used for jumps.
- `wr`  out  1  memory write strobe.
- `data_e`  out  1  accumulator-to-data-bus drive enable.
- `halted`  out  1  sticky halted status.
- `phase`  out  3  current `phase_t`, for debug.

## Operation
- `phase` advances 0→7→0 on each `clk` edge with `ena`=1. It holds when `ena`=0 or `halted`=1.
- ALUOP means the opcode is ADD, AND, XOR or LDA.
- Decode per phase. Any signal not listed is 0.
  - INST_ADDR (0): `sel`.
  - INST_FETCH (1): `sel`, `rd`.
  - INST_LOAD (2): `sel`, `rd`, `ld_ir`.
  - IDLE (3): `sel`, `rd`, `ld_ir`.
  - OP_ADDR (4): `halt`=(op==HLT), `inc_pc`.
  - OP_FETCH (5): `rd`=ALUOP.
  - ALU_OP (6): `rd`=ALUOP, `inc_pc`=(op==SKZ && `zero`), `ld_pc`=(op==JMP), `data_e`=(op==STO).
  - STORE (7): `rd`=ALUOP, `ld_ac`=ALUOP, `ld_pc`=(op==JMP), `wr`=(op==STO), `data_e`=(op==STO).
- Gating:
  - Strobes (`ld_ir`, `inc_pc`, `ld_ac`, `ld_pc`, `wr`) are ANDed with `ena`.
  - Levels (`sel`, `rd`, `data_e`, `halt`) are not gated.
- HLT handling:
  - In OP_ADDR with op==HLT and `ena`=1, `halt`=1 and `inc_pc`=1 for that cycle, so the PC moves past the HLT once.
  - `halted` is set at the clock edge that ends that cycle.
- While `halted`=1:
  - `phase` is frozen at OP_ADDR.
  - All outputs are 0 except `halt`=1 and `halted`=1.
  - `inc_pc` is forced to 0.
- Reset:
  - `rst_n` low, including mid-instruction or while halted, immediately forces `phase`=INST_ADDR and `halted`=0.
  - Reset outputs: `sel`=1, all other control outputs 0, `phase`=0.

## Timing
- Control outputs are combinational decode of the registered `phase`/`halted` plus the live `opcode` and `zero`. There are no extra register stages.
- One instruction takes exactly 8 enabled cycles. Stall cycles add 1:1.
- `zero` is consumed only in ALU_OP and must be stable in that cycle.
- `opcode` is valid from the cycle after IR load and must stay stable through STORE.
- Simultaneous `ena`=0 and a HLT opcode in OP_ADDR: no halt strobe is taken, and `halted` is not set until an enabled OP_ADDR cycle.
- `halted` rises exactly one cycle after the enabled HLT OP_ADDR cycle.

## Configuration
- Macro: `CTRL_RESUME_EN`.
- Defined:
  - The `resume` port exists.
  - `resume`=1 while `halted` clears `halted` at the next edge, and `phase` advances to OP_FETCH. Execution continues at the instruction after HLT.
  - `ena` is ignored for the resume edge.
- Undefined:
  - There is no `resume` port.
  - `halted` is cleared only by `rst_n`.

## Structure
- Add `phase_t` (3-bit enum: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE) to the shared opcodes package, next to `opcode_t`.
- Sub-module `ctrl_decode`: purely combinational mapping of (`phase`, `opcode`, `zero`) to the nine control outputs, with no gating.
- The top level holds the `phase` register, the `halted` register, the `ena` strobe gating and the halted override.

## Test plan
- Reset: assert `rst_n`=0 in STORE of a STO → immediately `phase`=0, `sel`=1, `wr`=0, `data_e`=0, `halted`=0.
- LDA with `ena`=1 for 8 cycles → `rd`=1 in phases 1–3 and 5–7; `ld_ir`=1 in phases 2–3; `inc_pc`=1 in phase 4 only; `ld_ac`=1 in phase 7 only.
- SKZ with `zero`=1 → `inc_pc`=1 in phases 4 and 6. Repeat with `zero`=0 → `inc_pc`=1 in phase 4 only.
- STO → `data_e`=1 in phases 6–7, `wr`=1 in phase 7 only, `rd`=0 in phases 5–7. JMP → `ld_pc`=1 in phases 6–7.
- HLT:
  - Phase 4 shows `halt`=1 and `inc_pc`=1 for one cycle, then `halted`=1 and `phase` stays 4 with `inc_pc`=0 for 20 cycles.
  - With `CTRL_RESUME_EN`, a 1-cycle `resume` pulse gives `phase`=5 and `halted`=0 on the next edge.
- Stall: `ena`=0 for 3 cycles entering phase 2 → `phase` holds at 2 and `ld_ir`=0 while stalled with `sel`=`rd`=1. `ena` back to 1 → `ld_ir`=1, then phase 3.
